wb_stage: RTL and testbench

- Writeback stage of the NPC core. Sits directly upstream of the register file and drives its write port (wen/waddr/wdata) plus the retiring PC.
- Accepts one completed instruction at a time from the execute/LSU side.
- For ALU results, forwards the result after one registered cycle.
- For loads, waits for the memory response, then aligns and sign/zero-extends the data before writing.
- Also exports the pending load destination for decode-stage hazard stalls, and flags load timeouts and misaligned loads.

---
 rtl/wb_if.sv | 39 +++
 rtl/wb_stage.sv | 143 ++++++++++++++
 tb/tb_wb_stage.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_if.sv
// Writeback-stage bus: execute offer/handshake, memory load response and
// register-file write port with hazard/error status.
interface wb_if;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_pc;
  logic [4:0]  ex_rd;
  logic        ex_rd_wen;
  logic [31:0] ex_result;
  logic        ex_is_load;
  logic [1:0]  ex_ld_size;
  logic        ex_ld_unsigned;
  logic [1:0]  ex_addr_lo;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] rf_pc;
  logic        retire_valid;
  logic        pending_valid;
  logic [4:0]  pending_rd;
  logic        misalign_err;
  logic        timeout_err;

  modport slave (
    input  ex_valid, ex_pc, ex_rd, ex_rd_wen, ex_result, ex_is_load,
           ex_ld_size, ex_ld_unsigned, ex_addr_lo, mem_rvalid, mem_rdata,
    output ex_ready, rf_wen, rf_waddr, rf_wdata, rf_pc, retire_valid,
           pending_valid, pending_rd, misalign_err, timeout_err
  );

  modport master (
    output ex_valid, ex_pc, ex_rd, ex_rd_wen, ex_result, ex_is_load,
           ex_ld_size, ex_ld_unsigned, ex_addr_lo, mem_rvalid, mem_rdata,
    input  ex_ready, rf_wen, rf_waddr, rf_wdata, rf_pc, retire_valid,
           pending_valid, pending_rd, misalign_err, timeout_err
  );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: retires ALU results one cycle after transfer and loads
// one cycle after the memory response, with alignment and extension.
module wb_stage #(
  parameter int          TIMEOUT  = 1024,
  parameter logic [31:0] RESET_PC = 32'h80000000
) (
  input  logic clk,
  input  logic rst,
  wb_if.slave  bus
);
  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic {IDLE, WAIT_LOAD} state_t;

  state_t      state_reg;
  logic [31:0] ld_pc_reg;
  logic [4:0]  ld_rd_reg;
  logic        ld_wen_reg;
  logic [1:0]  ld_size_reg;
  logic        ld_unsigned_reg;
  logic [1:0]  ld_addr_lo_reg;
  logic [CW-1:0] cnt_reg;

  logic        rf_wen_reg;
  logic [4:0]  rf_waddr_reg;
  logic [31:0] rf_wdata_reg;
  logic [31:0] rf_pc_reg;
  logic        retire_valid_reg;
  logic        pending_valid_reg;
  logic [4:0]  pending_rd_reg;
  logic        misalign_err_reg;
  logic        timeout_err_reg;

  logic [7:0]  lane [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;
  logic        misaligned;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane[gi] = bus.mem_rdata[8*gi +: 8];
    end
  endgenerate

  assign byte_sel = lane[ld_addr_lo_reg];
  assign half_sel = ld_addr_lo_reg[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

  always_comb begin
    load_data  = bus.mem_rdata;
    misaligned = 1'b0;
    case (ld_size_reg)
      2'b00: load_data = ld_unsigned_reg ? {24'b0, byte_sel}
                                         : {{24{byte_sel[7]}}, byte_sel};
      2'b01: begin
        load_data  = ld_unsigned_reg ? {16'b0, half_sel}
                                     : {{16{half_sel[15]}}, half_sel};
        misaligned = ld_addr_lo_reg[0];
      end
      2'b10: misaligned = (ld_addr_lo_reg != 2'b00);
      default: misaligned = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= IDLE;
      ld_pc_reg         <= '0;
      ld_rd_reg         <= '0;
      ld_wen_reg        <= 1'b0;
      ld_size_reg       <= '0;
      ld_unsigned_reg   <= 1'b0;
      ld_addr_lo_reg    <= '0;
      cnt_reg           <= '0;
      rf_wen_reg        <= 1'b0;
      rf_waddr_reg      <= '0;
      rf_wdata_reg      <= '0;
      rf_pc_reg         <= RESET_PC;
      retire_valid_reg  <= 1'b0;
      pending_valid_reg <= 1'b0;
      pending_rd_reg    <= '0;
      misalign_err_reg  <= 1'b0;
      timeout_err_reg   <= 1'b0;
    end else begin
      rf_wen_reg       <= 1'b0;
      retire_valid_reg <= 1'b0;
      misalign_err_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.ex_valid) begin
            if (!bus.ex_is_load) begin
              rf_wen_reg       <= bus.ex_rd_wen && (bus.ex_rd != 5'd0);
              rf_waddr_reg     <= bus.ex_rd;
              rf_wdata_reg     <= bus.ex_result;
              rf_pc_reg        <= bus.ex_pc;
              retire_valid_reg <= 1'b1;
            end else begin
              ld_pc_reg         <= bus.ex_pc;
              ld_rd_reg         <= bus.ex_rd;
              ld_wen_reg        <= bus.ex_rd_wen;
              ld_size_reg       <= bus.ex_ld_size;
              ld_unsigned_reg   <= bus.ex_ld_unsigned;
              ld_addr_lo_reg    <= bus.ex_addr_lo;
              cnt_reg           <= '0;
              pending_valid_reg <= bus.ex_rd_wen && (bus.ex_rd != 5'd0);
              pending_rd_reg    <= bus.ex_rd;
              state_reg         <= WAIT_LOAD;
            end
          end
        end
        WAIT_LOAD: begin
          if (bus.mem_rvalid) begin
            rf_wen_reg        <= ld_wen_reg && (ld_rd_reg != 5'd0) && !misaligned;
            rf_waddr_reg      <= ld_rd_reg;
            rf_wdata_reg      <= load_data;
            rf_pc_reg         <= ld_pc_reg;
            retire_valid_reg  <= 1'b1;
            misalign_err_reg  <= misaligned;
            pending_valid_reg <= 1'b0;
            state_reg         <= IDLE;
          end else if (cnt_reg != CW'(TIMEOUT)) begin
            // Counter saturates; the error flag stays set until reset.
            cnt_reg <= cnt_reg + 1'b1;
            if (cnt_reg + 1'b1 == CW'(TIMEOUT)) timeout_err_reg <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.ex_ready      = (state_reg == IDLE) && !rst;
  assign bus.rf_wen        = rf_wen_reg;
  assign bus.rf_waddr      = rf_waddr_reg;
  assign bus.rf_wdata      = rf_wdata_reg;
  assign bus.rf_pc         = rf_pc_reg;
  assign bus.retire_valid  = retire_valid_reg;
  assign bus.pending_valid = pending_valid_reg;
  assign bus.pending_rd    = pending_rd_reg;
  assign bus.misalign_err  = misalign_err_reg;
  assign bus.timeout_err   = timeout_err_reg;
endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: a transaction-level model predicts every
// output each cycle, plus literal spot checks on key results.
module tb_wb_stage;
  localparam int          TO   = 8;
  localparam logic [31:0] RPC  = 32'h80000000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  wb_if bus();

  wb_stage #(.TIMEOUT(TO), .RESET_PC(RPC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit started  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] sz,
                                          input logic [1:0] lo, input logic uns);
    logic [31:0] v;
    case (sz)
      2'd0: begin
        v = (w >> (8 * lo)) & 32'h000000FF;
        if (!uns && v[7]) v = v | 32'hFFFFFF00;
      end
      2'd1: begin
        v = (w >> (16 * lo[1])) & 32'h0000FFFF;
        if (!uns && v[15]) v = v | 32'hFFFF0000;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  function automatic bit aligned(input logic [1:0] sz, input logic [1:0] lo);
    if (sz == 2'd0) return 1'b1;
    if (sz == 2'd1) return (lo % 2) == 0;
    if (sz == 2'd2) return lo == 2'd0;
    return 1'b0;
  endfunction

  // Model: one outstanding load at most; expectations updated per clock edge.
  bit          busy;
  int          waited;
  logic [31:0] c_pc;
  logic [4:0]  c_rd;
  logic        c_wen, c_uns;
  logic [1:0]  c_sz, c_lo;
  logic        e_ret, e_wen, e_pend, e_mis, e_to;
  logic [4:0]  e_waddr, e_prd;
  logic [31:0] e_wdata, e_pc;

  always @(posedge clk) begin
    started = 1;
    if (rst) begin
      busy = 0; waited = 0;
      e_ret = 0; e_wen = 0; e_pend = 0; e_mis = 0; e_to = 0;
      e_waddr = 0; e_prd = 0; e_wdata = 0; e_pc = RPC;
    end else begin
      e_ret = 0; e_wen = 0; e_mis = 0;
      if (!busy) begin
        if (bus.ex_valid && !bus.ex_is_load) begin
          e_ret = 1;
          e_wen = bus.ex_rd_wen && bus.ex_rd != 0;
          e_waddr = bus.ex_rd; e_wdata = bus.ex_result; e_pc = bus.ex_pc;
        end else if (bus.ex_valid) begin
          busy = 1; waited = 0;
          c_pc = bus.ex_pc; c_rd = bus.ex_rd; c_wen = bus.ex_rd_wen;
          c_sz = bus.ex_ld_size; c_uns = bus.ex_ld_unsigned; c_lo = bus.ex_addr_lo;
          e_pend = c_wen && c_rd != 0; e_prd = c_rd;
        end
      end else if (bus.mem_rvalid) begin
        e_ret = 1;
        e_mis = !aligned(c_sz, c_lo);
        e_wen = c_wen && c_rd != 0 && !e_mis;
        e_waddr = c_rd; e_wdata = extract(bus.mem_rdata, c_sz, c_lo, c_uns);
        e_pc = c_pc; busy = 0; e_pend = 0;
      end else begin
        waited++;
        if (waited >= TO) e_to = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("ex_ready", bus.ex_ready, !busy && !rst);
      chk("retire_valid", bus.retire_valid, e_ret);
      chk("rf_wen", bus.rf_wen, e_wen);
      if (e_wen) begin
        chk("rf_waddr", bus.rf_waddr, e_waddr);
        chk("rf_wdata", bus.rf_wdata, e_wdata);
      end
      chk("rf_pc", bus.rf_pc, e_pc);
      chk("pending_valid", bus.pending_valid, e_pend);
      if (e_pend) chk("pending_rd", bus.pending_rd, e_prd);
      chk("misalign_err", bus.misalign_err, e_mis);
      chk("timeout_err", bus.timeout_err, e_to);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic alu(input logic [31:0] pc, input logic [4:0] rd, input logic wen,
                     input logic [31:0] res);
    $display("ALU  pc=%h rd=%0d wen=%0b result=%h", pc, rd, wen, res);
    bus.ex_valid = 1; bus.ex_is_load = 0; bus.ex_pc = pc; bus.ex_rd = rd;
    bus.ex_rd_wen = wen; bus.ex_result = res;
    @(posedge clk); #1;
    bus.ex_valid = 0;
  endtask

  task automatic load(input logic [31:0] pc, input logic [4:0] rd, input logic [1:0] sz,
                      input logic uns, input logic [1:0] lo);
    $display("LOAD pc=%h rd=%0d size=%0d uns=%0b lo=%0d", pc, rd, sz, uns, lo);
    bus.ex_valid = 1; bus.ex_is_load = 1; bus.ex_pc = pc; bus.ex_rd = rd;
    bus.ex_rd_wen = 1; bus.ex_result = 32'hDEADBEEF; bus.ex_ld_size = sz;
    bus.ex_ld_unsigned = uns; bus.ex_addr_lo = lo;
    @(posedge clk); #1;
    bus.ex_valid = 0; bus.ex_is_load = 0;
  endtask

  task automatic mem_resp(input logic [31:0] d);
    $display("MEM  rdata=%h", d);
    bus.mem_rvalid = 1; bus.mem_rdata = d;
    @(posedge clk); #1;
    bus.mem_rvalid = 0;
  endtask

  task automatic load_rsp(input logic [1:0] sz, input logic uns, input logic [1:0] lo,
                          input logic [31:0] d, input logic [31:0] want);
    load(32'h80000100, 5'd12, sz, uns, lo);
    idle(1);
    mem_resp(d);
    @(negedge clk);
    chk("load_wdata_lit", bus.rf_wdata, want);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ex_valid = 0; bus.ex_pc = 0; bus.ex_rd = 0; bus.ex_rd_wen = 0;
    bus.ex_result = 0; bus.ex_is_load = 0; bus.ex_ld_size = 0;
    bus.ex_ld_unsigned = 0; bus.ex_addr_lo = 0; bus.mem_rvalid = 0; bus.mem_rdata = 0;

    chk("model_lb",  extract(32'h80112233, 2'd0, 2'd3, 1'b0), 32'hFFFFFF80);
    chk("model_lhu", extract(32'hBEEF0000, 2'd1, 2'd2, 1'b1), 32'h0000BEEF);
    chk("model_lh",  extract(32'hBEEF0000, 2'd1, 2'd2, 1'b0), 32'hFFFFBEEF);

    idle(2);
    @(negedge clk);
    chk("rst_pc", bus.rf_pc, 32'h80000000);
    chk("rst_waddr", bus.rf_waddr, 32'd0);
    chk("rst_wdata", bus.rf_wdata, 32'd0);
    @(posedge clk); #1;
    rst = 0;

    alu(32'h80000000, 5'd5, 1'b1, 32'h12345678);
    @(negedge clk);
    chk("alu_wen", bus.rf_wen, 1);
    chk("alu_waddr", bus.rf_waddr, 5);
    chk("alu_wdata", bus.rf_wdata, 32'h12345678);
    #1;
    alu(32'h80000004, 5'd0, 1'b1, 32'hFFFFFFFF);
    @(negedge clk);
    chk("x0_retire", bus.retire_valid, 1);
    chk("x0_wen", bus.rf_wen, 0);
    #1;

    load(32'h80000008, 5'd10, 2'd0, 1'b0, 2'd3);
    idle(2);
    @(negedge clk);
    chk("lb_pend", bus.pending_valid, 1);
    chk("lb_prd", bus.pending_rd, 10);
    chk("lb_busy", bus.ex_ready, 0);
    #1;
    mem_resp(32'h80112233);
    @(negedge clk);
    chk("lb_wdata", bus.rf_wdata, 32'hFFFFFF80);
    chk("lb_ready", bus.ex_ready, 1);
    #1;

    load_rsp(2'd1, 1'b1, 2'd2, 32'hBEEF0000, 32'h0000BEEF);
    load_rsp(2'd1, 1'b0, 2'd2, 32'hBEEF0000, 32'hFFFFBEEF);
    load_rsp(2'd0, 1'b1, 2'd1, 32'h0000A500, 32'h000000A5);
    load_rsp(2'd1, 1'b0, 2'd0, 32'h00008001, 32'hFFFF8001);
    load_rsp(2'd2, 1'b1, 2'd0, 32'hCAFEF00D, 32'hCAFEF00D);

    load(32'h80000200, 5'd9, 2'd2, 1'b0, 2'd1);
    mem_resp(32'h01020304);
    @(negedge clk);
    chk("lw_mis_err", bus.misalign_err, 1);
    chk("lw_mis_wen", bus.rf_wen, 0);
    #1;
    load(32'h80000204, 5'd9, 2'd3, 1'b0, 2'd0);
    mem_resp(32'h01020304);
    load(32'h80000208, 5'd0, 2'd2, 1'b0, 2'd0);
    mem_resp(32'h55555555);

    mem_resp(32'h77777777);
    idle(1);

    load(32'h80000300, 5'd7, 2'd2, 1'b0, 2'd0);
    idle(10);
    @(negedge clk);
    chk("to_set", bus.timeout_err, 1);
    #1;
    mem_resp(32'h11223344);
    idle(3);
    @(negedge clk);
    chk("to_sticky", bus.timeout_err, 1);
    #1;
    rst = 1;
    idle(1);
    rst = 0;
    @(negedge clk);
    chk("to_clear", bus.timeout_err, 0);
    #1;

    load(32'h80000400, 5'd3, 2'd2, 1'b0, 2'd0);
    idle(2);
    rst = 1; bus.mem_rvalid = 1; bus.mem_rdata = 32'hABCDABCD;
    $display("RST  during WAIT_LOAD with mem_rvalid");
    @(posedge clk); #1;
    rst = 0; bus.mem_rvalid = 0;
    @(negedge clk);
    chk("rstw_retire", bus.retire_valid, 0);
    chk("rstw_pend", bus.pending_valid, 0);
    chk("rstw_pc", bus.rf_pc, 32'h80000000);
    #1;
    alu(32'h80000500, 5'd1, 1'b1, 32'h00000001);
    alu(32'h80000504, 5'd2, 1'b1, 32'h00000002);
    alu(32'h80000508, 5'd3, 1'b1, 32'h00000003);
    @(negedge clk);
    chk("b2b_wdata", bus.rf_wdata, 32'h00000003);
    chk("b2b_pc", bus.rf_pc, 32'h80000508);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
